// File: rtl/fregs_write_arbiter.sv
// ============================================================================
// Module   : fregs_write_arbiter
// Purpose  : Arbitrates the FPU result path and the FLW load path onto the
//            single FP register-file write port. Also keeps a pending-write
//            scoreboard that drives the issue-stage RAW/WAW hazard check.
// Options  : FWARB_RR_EN - round-robin arbitration on contention
//                          (default: fixed priority, load beats FPU)
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fregs_write_arbiter #(
    parameter int DATA_W    = 32,
    parameter int NREG_LOG2 = 5
) (
    input  logic                        iCLK,
    input  logic                        iRST,
    input  logic                        iFpuValid,
    output logic                        oFpuReady,
    input  logic [NREG_LOG2-1:0]        iFpuRd,
    input  logic [DATA_W-1:0]           iFpuData,
    input  logic                        iLdValid,
    output logic                        oLdReady,
    input  logic [NREG_LOG2-1:0]        iLdRd,
    input  logic [DATA_W-1:0]           iLdData,
    input  logic                        iIssue,
    input  logic [NREG_LOG2-1:0]        iIssueRd,
    input  logic                        iFlush,
    input  logic [NREG_LOG2-1:0]        iRs1,
    input  logic [NREG_LOG2-1:0]        iRs2,
    input  logic [NREG_LOG2-1:0]        iRs3,
    output logic                        oHazard,
    output logic                        oRegWrite,
    output logic [NREG_LOG2-1:0]        oWriteRegister,
    output logic [DATA_W-1:0]           oWriteData,
    output logic [(1<<NREG_LOG2)-1:0]   oPending,
    output logic                        oErr
);

    localparam int c_NREG = 1 << NREG_LOG2;

    logic                   r_fpu_full;
    logic [NREG_LOG2-1:0]   r_fpu_rd;
    logic [DATA_W-1:0]      r_fpu_data;
    logic                   r_ld_full;
    logic [NREG_LOG2-1:0]   r_ld_rd;
    logic [DATA_W-1:0]      r_ld_data;

    logic                   r_regwrite;
    logic [NREG_LOG2-1:0]   r_wreg;
    logic [DATA_W-1:0]      r_wdata;
    logic [c_NREG-1:0]      r_pending;
    logic                   r_err;

    logic                   w_gnt_ld;
    logic                   w_gnt_fpu;
    logic                   w_fpu_acc;
    logic                   w_ld_acc;
    logic                   w_issue;
    logic                   w_issue_err;
    logic [c_NREG-1:0]      w_clr_mask;
    logic [c_NREG-1:0]      w_set_mask;

`ifdef FWARB_RR_EN
    // 1: load wins the next contended cycle, 0: FPU wins
    logic                   r_rr_ld;

    always_comb begin
        w_gnt_ld  = r_ld_full && (!r_fpu_full || r_rr_ld);
        w_gnt_fpu = r_fpu_full && !w_gnt_ld;
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_rr_ld <= 1'b1;
        end else if (!iFlush) begin
            if (w_gnt_ld)
                r_rr_ld <= 1'b0;
            else if (w_gnt_fpu)
                r_rr_ld <= 1'b1;
        end
    end
`else
    // The memory path cannot stall, so load always beats FPU
    always_comb begin
        w_gnt_ld  = r_ld_full;
        w_gnt_fpu = r_fpu_full && !w_gnt_ld;
    end
`endif

    // A buffer being drained this edge can be refilled on the same edge
    assign oFpuReady = !iFlush && (!r_fpu_full || w_gnt_fpu);
    assign oLdReady  = !iFlush && (!r_ld_full  || w_gnt_ld);
    assign w_fpu_acc = iFpuValid && oFpuReady;
    assign w_ld_acc  = iLdValid  && oLdReady;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_fpu_full <= 1'b0;
            r_fpu_rd   <= '0;
            r_fpu_data <= '0;
            r_ld_full  <= 1'b0;
            r_ld_rd    <= '0;
            r_ld_data  <= '0;
        end else if (iFlush) begin
            r_fpu_full <= 1'b0;
            r_ld_full  <= 1'b0;
        end else begin
            if (w_fpu_acc) begin
                r_fpu_full <= 1'b1;
                r_fpu_rd   <= iFpuRd;
                r_fpu_data <= iFpuData;
            end else if (w_gnt_fpu) begin
                r_fpu_full <= 1'b0;
            end
            if (w_ld_acc) begin
                r_ld_full <= 1'b1;
                r_ld_rd   <= iLdRd;
                r_ld_data <= iLdData;
            end else if (w_gnt_ld) begin
                r_ld_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_regwrite <= 1'b0;
            r_wreg     <= '0;
            r_wdata    <= '0;
        end else if (iFlush) begin
            r_regwrite <= 1'b0;
        end else if (w_gnt_ld) begin
            r_regwrite <= 1'b1;
            r_wreg     <= r_ld_rd;
            r_wdata    <= r_ld_data;
        end else if (w_gnt_fpu) begin
            r_regwrite <= 1'b1;
            r_wreg     <= r_fpu_rd;
            r_wdata    <= r_fpu_data;
        end else begin
            r_regwrite <= 1'b0;
        end
    end

    // Clear happens on the register-file write edge; a same-edge set wins
    always_comb begin
        w_clr_mask = '0;
        w_set_mask = '0;
        w_issue    = iIssue && !iFlush;
        if (r_regwrite)
            w_clr_mask[r_wreg] = 1'b1;
        if (w_issue)
            w_set_mask[iIssueRd] = 1'b1;
        w_issue_err = w_issue && r_pending[iIssueRd] && !w_clr_mask[iIssueRd];
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_pending <= '0;
            r_err     <= 1'b0;
        end else begin
            if (iFlush)
                r_pending <= '0;
            else
                r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
            if (w_issue_err)
                r_err <= 1'b1;
        end
    end

    assign oHazard        = r_pending[iRs1] | r_pending[iRs2] |
                            r_pending[iRs3] | r_pending[iIssueRd];
    assign oRegWrite      = r_regwrite;
    assign oWriteRegister = r_wreg;
    assign oWriteData     = r_wdata;
    assign oPending       = r_pending;
    assign oErr           = r_err;

endmodule

`default_nettype wire
